// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - thermometer chain conversion sequencer
// Clears the chain, enables the comparators for a bounded window, then accumulates NSAMP popcounts.
module conv_sequencer #(
   parameter int NBITS   = 10,
   parameter int NSAMP   = 4,
   parameter int WINDOW  = 8,
   parameter int CLR_CYC = 2,
   localparam int W      = $clog2(NBITS + 1),
   localparam int RW     = W + $clog2(NSAMP),
   localparam int SCW    = $clog2(NSAMP + 1)
) (
   input  logic             clock,
   input  logic             res,
   input  logic             start,
   input  logic             abort,
   input  logic [NBITS-1:0] clc,
   input  logic             out_ready,
   output logic             comp_en,
   output logic             chain_clr,
   output logic             busy,
   output logic [RW-1:0]    result,
   output logic             result_valid,
   output logic             sat,
   output logic             bubble
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, ARM, WAIT, SETTLE, CAPTURE, OUTPUT
   } state_t;

   state_t           r_state, w_next;
   logic [NBITS-1:0] r_clc_m, r_clc_s;
   logic [3:0]       r_clr_cnt;
   logic [7:0]       r_win_cnt;
   logic             r_settle_cnt;
   logic [SCW-1:0]   r_samp_cnt;
   logic [RW-1:0]    r_acc;
   logic             r_sat, r_bubble;
   logic [W-1:0]     w_code;
   logic             w_bubble;
   logic [SCW-1:0]   w_samp_inc;

   always_comb begin
      w_code = '0;
      for (int i = 0; i < NBITS; i++) w_code = w_code + W'(r_clc_s[i]);
   end

   // a 1 above a 0 means the thermometer is not monotonic
   assign w_bubble   = |(r_clc_s[NBITS-1:1] & ~r_clc_s[NBITS-2:0]);
   assign w_samp_inc = r_samp_cnt + SCW'(1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = CLEAR;
         CLEAR:   if (r_clr_cnt == 4'(CLR_CYC - 1)) w_next = ARM;
         ARM:     w_next = WAIT;
         WAIT:    if (r_clc_s[NBITS-1] || r_win_cnt == 8'(WINDOW - 1)) w_next = SETTLE;
         SETTLE:  if (r_settle_cnt) w_next = CAPTURE;
         CAPTURE: w_next = (w_samp_inc == SCW'(NSAMP)) ? OUTPUT : CLEAR;
         OUTPUT:  if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (abort) w_next = IDLE;
   end

   always_ff @(posedge clock or negedge res) begin
      if (!res) begin
         r_state      <= IDLE;
         r_clc_m      <= '0;
         r_clc_s      <= '0;
         r_clr_cnt    <= '0;
         r_win_cnt    <= '0;
         r_settle_cnt <= 1'b0;
         r_samp_cnt   <= '0;
         r_acc        <= '0;
         r_sat        <= 1'b0;
         r_bubble     <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_clc_m      <= clc;
         r_clc_s      <= r_clc_m;
         r_clr_cnt    <= (r_state == CLEAR) ? r_clr_cnt + 4'd1 : 4'd0;
         r_settle_cnt <= (r_state == SETTLE) ? ~r_settle_cnt : 1'b0;
         if (r_state == ARM)
            r_win_cnt <= '0;
         else if (r_state == WAIT)
            r_win_cnt <= r_win_cnt + 8'd1;
         if (r_state == IDLE && start) begin
            r_acc      <= '0;
            r_samp_cnt <= '0;
            r_sat      <= 1'b0;
            r_bubble   <= 1'b0;
         end else if (r_state == CAPTURE) begin
            r_acc      <= r_acc + RW'(w_code);
            r_samp_cnt <= w_samp_inc;
            r_sat      <= r_sat | (w_code == W'(NBITS));
            r_bubble   <= r_bubble | w_bubble;
         end
      end
   end

   // outputs are pure decodes of the state register, so they drop the instant reset asserts
   assign comp_en      = (r_state == ARM) || (r_state == WAIT);
   assign chain_clr    = (r_state == CLEAR);
   assign busy         = (r_state != IDLE);
   assign result_valid = (r_state == OUTPUT);
   assign result       = result_valid ? r_acc : '0;
   assign sat          = result_valid & r_sat;
   assign bubble       = result_valid & r_bubble;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - scoreboard bench for conv_sequencer
module tb_conv_sequencer;
   localparam int NBITS = 10, NSAMP = 4, WINDOW = 8, CLR_CYC = 2, RW = 6;

   logic clock = 1'b0, res = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic [NBITS-1:0] clc = '0;
   logic comp_en, chain_clr, busy, result_valid, sat, bubble;
   logic [RW-1:0] result;

   conv_sequencer #(.NBITS(NBITS), .NSAMP(NSAMP), .WINDOW(WINDOW), .CLR_CYC(CLR_CYC)) dut (
      .clock(clock), .res(res), .start(start), .abort(abort), .clc(clc),
      .out_ready(out_ready), .comp_en(comp_en), .chain_clr(chain_clr), .busy(busy),
      .result(result), .result_valid(result_valid), .sat(sat), .bubble(bubble)
   );

   always #5 clock = ~clock;

   typedef struct {
      int res;
      int sat;
      int bub;
      int lat;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0, errors = 0;
   logic [NBITS-1:0] tbl [NSAMP];
   int samp_idx = 0;
   logic prev_clr = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t model();
      exp_t e;
      e.res = 0; e.sat = 0; e.bub = 0; e.lat = 0;
      for (int s = 0; s < NSAMP; s++) begin
         int v;
         v = int'(tbl[s]);
         e.res += $countones(tbl[s]);
         if (v == (1 << NBITS) - 1) e.sat = 1;
         if ((v & (v + 1)) != 0) e.bub = 1;
         e.lat += CLR_CYC + 1 + (tbl[s][NBITS-1] ? 1 : WINDOW) + 2 + 1;
      end
      return e;
   endfunction

   // chain driver: presents the next table entry at the start of each clear phase
   always begin
      @(posedge clock);
      #1;
      if (!busy) samp_idx = 0;
      else if (chain_clr && !prev_clr && samp_idx < NSAMP) begin
         clc = tbl[samp_idx];
         samp_idx++;
      end
      prev_clr = chain_clr;
   end

   int lat_cnt = 0;
   bit have_hold = 0, prev_xfer = 0;
   logic [RW-1:0] h_res;
   logic h_sat, h_bub;

   always @(negedge clock) begin
      if (!res) begin
         lat_cnt = 0; have_hold = 0; prev_xfer = 0;
      end else begin
         if (comp_en && chain_clr) check("comp_en_and_chain_clr", 1, 0);
         if (prev_xfer) check("valid_drops_after_xfer", int'(result_valid), 0);
         prev_xfer = 0;
         if (!busy) begin
            lat_cnt = 0; have_hold = 0;
         end else if (!result_valid) lat_cnt++;
         if (result_valid) begin
            if (have_hold) begin
               check("hold_result", int'(result), int'(h_res));
               check("hold_sat", int'(sat), int'(h_sat));
               check("hold_bubble", int'(bubble), int'(h_bub));
            end
            if (out_ready) begin
               if (exp_q.size() == 0) check("unexpected_result", 1, 0);
               else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("result", int'(result), e.res);
                  check("sat", int'(sat), e.sat);
                  check("bubble", int'(bubble), e.bub);
                  check("latency", lat_cnt, e.lat);
               end
               have_hold = 0;
               prev_xfer = 1;
            end else begin
               h_res = result; h_sat = sat; h_bub = bubble; have_hold = 1;
            end
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic start_conv();
      exp_q.push_back(model());
      @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      check("start_chain_clr", int'(chain_clr), 1);
      check("start_busy", int'(busy), 1);
   endtask

   task automatic wait_idle(input bit rnd);
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge clock);
         #1;
         if (rnd) out_ready = ($urandom_range(0, 2) != 0);
         if (!busy) done = 1;
      end
      if (!done) check("wait_idle_timeout", 1, 0);
      out_ready = 1'b1;
   endtask

   task automatic fill(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                       input logic [NBITS-1:0] c, input logic [NBITS-1:0] d);
      tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
   endtask

   initial begin
      cyc(3);
      check("rst_comp_en", int'(comp_en), 0);
      check("rst_chain_clr", int'(chain_clr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_result", int'(result), 0);
      check("rst_valid", int'(result_valid), 0);
      check("rst_sat", int'(sat) + int'(bubble), 0);
      @(negedge clock) res = 1'b1;
      out_ready = 1'b1;

      fill(10'h00F, 10'h00F, 10'h00F, 10'h00F);
      start_conv();
      wait_idle(0);

      fill(10'h00F, 10'h3FF, 10'h00F, 10'h00F);
      start_conv();
      wait_idle(0);

      fill(10'h00B, 10'h007, 10'h007, 10'h007);
      start_conv();
      wait_idle(0);

      // reset asserted in the middle of WAIT
      fill(10'h00F, 10'h00F, 10'h00F, 10'h00F);
      start_conv();
      begin
         bit seen = 0;
         for (int i = 0; i < 100 && !seen; i++) begin
            cyc(1);
            if (comp_en) seen = 1;
         end
         if (!seen) check("reset_wait_timeout", 1, 0);
      end
      cyc(3);
      #2 res = 1'b0;
      #1;
      void'(exp_q.pop_back());
      check("arst_comp_en", int'(comp_en), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_chain_clr", int'(chain_clr), 0);
      check("arst_valid", int'(result_valid), 0);
      @(negedge clock) res = 1'b1;
      cyc(5);
      check("arst_no_restart", int'(busy), 0);

      // backpressure with an ignored start in OUTPUT
      out_ready = 1'b0;
      start_conv();
      begin
         bit seen = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            cyc(1);
            if (result_valid) seen = 1;
         end
         if (!seen) check("bp_valid_timeout", 1, 0);
      end
      for (int k = 0; k < 5; k++) begin
         start = (k == 1);
         cyc(1);
      end
      start = 1'b0;
      check("bp_still_valid", int'(result_valid), 1);
      out_ready = 1'b1;
      cyc(1);
      check("bp_idle_busy", int'(busy), 0);
      check("bp_idle_valid", int'(result_valid), 0);
      cyc(3);
      check("bp_start_ignored", int'(busy), 0);

      // abort during WAIT of sample 3
      start_conv();
      begin
         bit seen = 0;
         for (int i = 0; i < 200 && !seen; i++) begin
            cyc(1);
            if (samp_idx == 3 && comp_en) seen = 1;
         end
         if (!seen) check("abort_wait_timeout", 1, 0);
      end
      cyc(2);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      void'(exp_q.pop_back());
      check("abort_comp_en", int'(comp_en), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_valid", int'(result_valid), 0);
      cyc(3);
      start_conv();
      wait_idle(0);

      for (int n = 0; n < 20; n++) begin
         for (int s = 0; s < NSAMP; s++) begin
            logic [NBITS-1:0] v;
            case ($urandom_range(0, 3))
               0: v = NBITS'((1 << $urandom_range(0, NBITS - 1)) - 1);
               1: v = '1;
               2: v = NBITS'($urandom);
               default: begin
                  v = NBITS'((1 << $urandom_range(0, NBITS - 1)) - 1);
                  v[$urandom_range(0, NBITS - 1)] ^= 1'b1;
               end
            endcase
            tbl[s] = v;
         end
         start_conv();
         wait_idle(1);
      end

      cyc(3);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
